// File: rtl/hall_pkg.sv
// Shared definitions for the six-step hall commutator:
// sector codes, FSM states, gate bit indices, commutation tables.
package hall_pkg;

  localparam logic [2:0] SEC_A = 3'd0;
  localparam logic [2:0] SEC_B = 3'd1;
  localparam logic [2:0] SEC_C = 3'd2;
  localparam logic [2:0] SEC_D = 3'd3;
  localparam logic [2:0] SEC_E = 3'd4;
  localparam logic [2:0] SEC_F = 3'd5;
  localparam logic [2:0] SECTOR_INVALID = 3'd7;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DEADTIME,
    ST_DRIVE
  } state_t;

  localparam int GHA = 5;
  localparam int GLA = 4;
  localparam int GHB = 3;
  localparam int GLB = 2;
  localparam int GHC = 1;
  localparam int GLC = 0;

  function automatic logic [2:0] hall_decode(
    input logic [2:0] code
  );
    logic [2:0] s;
    s = SECTOR_INVALID;
    case (code)
      3'b101:  s = SEC_A;
      3'b100:  s = SEC_B;
      3'b110:  s = SEC_C;
      3'b010:  s = SEC_D;
      3'b011:  s = SEC_E;
      3'b001:  s = SEC_F;
      default: s = SECTOR_INVALID;
    endcase
    return s;
  endfunction

  function automatic logic [5:0] comm_gate(
    input logic [2:0] sec,
    input logic       dir
  );
    logic [5:0] g;
    g = '0;
    case (sec)
      SEC_A: begin
        g[dir ? GHC : GHB] = 1'b1;
        g[dir ? GLB : GLC] = 1'b1;
      end
      SEC_B: begin
        g[dir ? GHA : GHB] = 1'b1;
        g[dir ? GLB : GLA] = 1'b1;
      end
      SEC_C: begin
        g[dir ? GHA : GHC] = 1'b1;
        g[dir ? GLC : GLA] = 1'b1;
      end
      SEC_D: begin
        g[dir ? GHB : GHC] = 1'b1;
        g[dir ? GLC : GLB] = 1'b1;
      end
      SEC_E: begin
        g[dir ? GHB : GHA] = 1'b1;
        g[dir ? GLA : GLB] = 1'b1;
      end
      SEC_F: begin
        g[dir ? GHC : GHA] = 1'b1;
        g[dir ? GLA : GLC] = 1'b1;
      end
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/hall_debounce.sv
// Two-flop synchroniser followed by a stability filter:
// a code is accepted after DEBOUNCE_CYCLES identical samples.
module hall_debounce
  import hall_pkg::*;
#(
  parameter int          W               = 3,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [W-1:0] RST_VAL        = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic [W-1:0] stable
);

  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;
  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] stable_q, stable_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         same;

  // Sample chain, saturating run counter and acceptance.
  always_comb begin
    s1_d     = din;
    s2_d     = s1_q;
    prev_d   = s2_q;
    same     = (s2_q == prev_q);
    cnt_d    = '0;
    stable_d = stable_q;
    if (same) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
    end
    if (same && cnt_d == CNT_MAX) begin
      stable_d = s2_q;
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= RST_VAL;
      s2_q     <= RST_VAL;
      prev_q   <= RST_VAL;
      stable_q <= RST_VAL;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sync   = s2_q;
  assign stable = stable_q;

endmodule

// File: rtl/hall_commutator.sv
// Six-step BLDC commutator with dead-time and fault latch.
// HALL_SPEED_EN adds the hall-period measurement.
module hall_commutator
  import hall_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEADTIME_CYCLES = 64,
  parameter int PERIOD_WIDTH    = 24
) (
  input  logic                    CLK,
  input  logic                    reset_n,
  input  logic [2:0]              hall,
  input  logic                    dir,
  input  logic                    enable,
  input  logic                    fault_n,
  output logic [5:0]              gate,
  output logic [2:0]              sector,
  output logic                    hall_error,
  output logic                    fault_latched,
  output logic                    dti_active,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid
);

  localparam logic [9:0] DT_MAX = 10'(DEADTIME_CYCLES - 1);

  logic [2:0] hall_sync_unused;
  logic [2:0] hall_stable;
  logic       flt_sync;
  logic       flt_stable;
  logic [2:0] sec_cur;
  logic       herr;

  hall_debounce #(
    .W(3),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_hall_db (
    .clk(CLK),
    .rst_n(reset_n),
    .din(hall),
    .sync(hall_sync_unused),
    .stable(hall_stable)
  );

  // Fault filter resets to "no fault" so reset release cannot latch one.
  hall_debounce #(
    .W(1),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_VAL(1'b1)
  ) u_flt_db (
    .clk(CLK),
    .rst_n(reset_n),
    .din(fault_n),
    .sync(flt_sync),
    .stable(flt_stable)
  );

  assign sec_cur    = hall_decode(hall_stable);
  assign herr       = (sec_cur == SECTOR_INVALID);
  assign sector     = sec_cur;
  assign hall_error = herr;

  logic       flt_q, flt_d;
  logic       flt_set;
  logic       fault;
  state_t     state_q, state_d;
  logic [9:0] dt_q, dt_d;
  logic [2:0] lsec_q, lsec_d;
  logic       ldir_q, ldir_d;
  logic [5:0] gate_q, gate_d;
  logic       stop;
  logic       chg;

  // Sticky fault; the raw set term also stops drive a cycle early.
  always_comb begin
    flt_set = !flt_sync;
    flt_d   = flt_q;
    if (flt_set) begin
      flt_d = 1'b1;
    end else if (!enable && flt_stable) begin
      flt_d = 1'b0;
    end
    fault = flt_q | flt_set;
  end

  // Commutation FSM next state, dead-time counter and gate pattern.
  always_comb begin
    state_d = state_q;
    dt_d    = dt_q;
    lsec_d  = lsec_q;
    ldir_d  = ldir_q;
    stop    = fault | herr | !enable;
    chg     = (sec_cur != lsec_q) || (dir != ldir_q);
    unique case (state_q)
      ST_OFF: begin
        if (!stop) begin
          state_d = ST_DEADTIME;
          dt_d    = DT_MAX;
          lsec_d  = sec_cur;
          ldir_d  = dir;
        end
      end
      ST_DEADTIME: begin
        if (stop) begin
          state_d = ST_OFF;
        end else if (chg) begin
          dt_d   = DT_MAX;
          lsec_d = sec_cur;
          ldir_d = dir;
        end else if (dt_q == '0) begin
          state_d = ST_DRIVE;
        end else begin
          dt_d = dt_q - 10'd1;
        end
      end
      ST_DRIVE: begin
        if (stop) begin
          state_d = ST_OFF;
        end else if (chg) begin
          state_d = ST_DEADTIME;
          dt_d    = DT_MAX;
          lsec_d  = sec_cur;
          ldir_d  = dir;
        end
      end
      default: state_d = ST_OFF;
    endcase
    gate_d = (state_d == ST_DRIVE) ? comm_gate(lsec_d, ldir_d) : '0;
  end

  // Control registers.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      flt_q   <= 1'b0;
      state_q <= ST_OFF;
      dt_q    <= '0;
      lsec_q  <= SECTOR_INVALID;
      ldir_q  <= 1'b0;
      gate_q  <= '0;
    end else begin
      flt_q   <= flt_d;
      state_q <= state_d;
      dt_q    <= dt_d;
      lsec_q  <= lsec_d;
      ldir_q  <= ldir_d;
      gate_q  <= gate_d;
    end
  end

  assign gate          = gate_q;
  assign fault_latched = flt_q;
  assign dti_active    = (state_q == ST_DEADTIME);

`ifdef HALL_SPEED_EN
  logic [PERIOD_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [PERIOD_WIDTH-1:0] per_q, per_d;
  logic                    pv_q, pv_d;
  logic [2:0]              psec_q, psec_d;

  // Free-running saturating counter captured on valid sector steps.
  always_comb begin
    psec_d = sec_cur;
    pcnt_d = (pcnt_q == '1) ? pcnt_q : pcnt_q + PERIOD_WIDTH'(1);
    per_d  = per_q;
    pv_d   = 1'b0;
    if (sec_cur != psec_q && !herr && psec_q != SECTOR_INVALID) begin
      per_d  = pcnt_q;
      pcnt_d = PERIOD_WIDTH'(1);
      pv_d   = 1'b1;
    end
  end

  // Period measurement registers.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q <= '0;
      per_q  <= '1;
      pv_q   <= 1'b0;
      psec_q <= SECTOR_INVALID;
    end else begin
      pcnt_q <= pcnt_d;
      per_q  <= per_d;
      pv_q   <= pv_d;
      psec_q <= psec_d;
    end
  end

  assign period       = per_q;
  assign period_valid = pv_q;
`else
  assign period       = '1;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_hall_commutator.sv
// Scoreboard bench for hall_commutator: stimulus queues expected gate
// changes with their cycle; a negedge monitor pops and compares them.
module tb_hall_commutator;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic [2:0]  hall;
  logic        dir;
  logic        enable;
  logic        fault_n;
  logic [5:0]  gate;
  logic [2:0]  sector;
  logic        hall_error;
  logic        fault_latched;
  logic        dti_active;
  logic [23:0] period;
  logic        period_valid;

  always #5 CLK = ~CLK;

  hall_commutator #(
    .DEBOUNCE_CYCLES(16),
    .DEADTIME_CYCLES(64),
    .PERIOD_WIDTH(24)
  ) dut (
    .CLK(CLK),
    .reset_n(reset_n),
    .hall(hall),
    .dir(dir),
    .enable(enable),
    .fault_n(fault_n),
    .gate(gate),
    .sector(sector),
    .hall_error(hall_error),
    .fault_latched(fault_latched),
    .dti_active(dti_active),
    .period(period),
    .period_valid(period_valid)
  );

  typedef struct {
    logic [5:0] g;
    int         t;
    string      name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pv_cnt = 0;
  logic [23:0] last_period = '0;
  logic [5:0]  last_gate = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic expect_gate(input logic [5:0] g, input int t,
                             input string n);
    exp_q.push_back('{g: g, t: t, name: n});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic bit gate_ok(input logic [5:0] g);
    bit ov;
    ov = (g[5] & g[4]) | (g[3] & g[2]) | (g[1] & g[0]);
    return !ov && $onehot0({g[5], g[3], g[1]}) &&
           $onehot0({g[4], g[2], g[0]});
  endfunction

  // Monitor: invariants every cycle, scoreboard on each gate change.
  always @(negedge CLK) begin
    if (reset_n) begin
      chk("gate_invariant", {31'b0, gate_ok(gate)}, 32'd1);
      if (gate !== last_gate) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_gate_change", {26'b0, gate}, {26'b0, last_gate});
        end else begin
          mon_e = exp_q.pop_front();
          chk({mon_e.name, "_gate"}, {26'b0, gate}, {26'b0, mon_e.g});
          chk({mon_e.name, "_cycle"}, cyc, mon_e.t);
        end
        last_gate = gate;
      end
      if (period_valid) begin
        pv_cnt++;
        last_period = period;
      end
    end
  end

  initial begin
    int c;
    reset_n = 1'b0;
    hall    = 3'b100;
    dir     = 1'b1;
    enable  = 1'b1;
    fault_n = 1'b1;
    step(3);
    chk("rst_gate", {26'b0, gate}, 32'h0);
    chk("rst_sector", {29'b0, sector}, 32'd7);
    chk("rst_hall_error", {31'b0, hall_error}, 32'd1);
    chk("rst_fault", {31'b0, fault_latched}, 32'd0);
    chk("rst_dti", {31'b0, dti_active}, 32'd0);
    chk("rst_period", {8'b0, period}, 32'h00ff_ffff);
    chk("rst_pv", {31'b0, period_valid}, 32'd0);

    reset_n = 1'b1;
    c = cyc;
    expect_gate(6'b100100, c + 83, "startup_B_fwd");
    step(100);
    chk("startup_sector", {29'b0, sector}, 32'd1);
    chk("startup_herr", {31'b0, hall_error}, 32'd0);
    chk("startup_dti", {31'b0, dti_active}, 32'd0);

    hall = 3'b110;
    step(3);
    hall = 3'b100;
    step(40);
    chk("glitch_sector", {29'b0, sector}, 32'd1);

    c = cyc;
    hall = 3'b110;
    expect_gate(6'b000000, c + 19, "stepC_off");
    expect_gate(6'b100001, c + 83, "stepC_on");
    step(50);
    chk("stepC_dti_mid", {31'b0, dti_active}, 32'd1);
    step(50);
    chk("stepC_dti_end", {31'b0, dti_active}, 32'd0);
    chk("stepC_sector", {29'b0, sector}, 32'd2);

    c = cyc;
    hall = 3'b100;
    expect_gate(6'b000000, c + 19, "backB_off");
    expect_gate(6'b100100, c + 83, "backB_on");
    step(100);

    c = cyc;
    dir = 1'b0;
    expect_gate(6'b000000, c + 1, "dir_off");
    expect_gate(6'b011000, c + 65, "dir_rev_B");
    step(100);

    c = cyc;
    fault_n = 1'b0;
    expect_gate(6'b000000, c + 3, "fault_off");
    step(1);
    fault_n = 1'b1;
    step(3);
    chk("fault_set", {31'b0, fault_latched}, 32'd1);
    step(40);
    chk("fault_sticky", {31'b0, fault_latched}, 32'd1);
    enable = 1'b0;
    step(3);
    chk("fault_clear", {31'b0, fault_latched}, 32'd0);
    step(5);
    c = cyc;
    enable = 1'b1;
    expect_gate(6'b011000, c + 65, "fault_recover");
    step(30);
    chk("recover_dti", {31'b0, dti_active}, 32'd1);
    step(70);

    c = cyc;
    hall = 3'b111;
    expect_gate(6'b000000, c + 19, "invalid_off");
    step(40);
    chk("invalid_sector", {29'b0, sector}, 32'd7);
    chk("invalid_herr", {31'b0, hall_error}, 32'd1);
    chk("invalid_gate", {26'b0, gate}, 32'h0);

    enable = 1'b0;
`ifdef HALL_SPEED_EN
    pv_cnt = 0;
`endif
    hall = 3'b100;
    step(1000);
    hall = 3'b110;
    step(1000);
    hall = 3'b010;
    step(100);
`ifdef HALL_SPEED_EN
    chk("speed_strobes", pv_cnt, 32'd2);
    chk("speed_period", {8'b0, last_period}, 32'd1000);
`else
    chk("no_speed_strobes", pv_cnt, 32'd0);
    chk("no_speed_period", {8'b0, period}, 32'h00ff_ffff);
`endif

    while (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: gate change to %b never seen (due cycle %0d)",
               mon_e.name, mon_e.g, mon_e.t);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
